// File: rtl/scrambler_64b66b_pkg.sv
// Shared constants for the 64b/66b self-synchronous scrambler (G(x) = 1 + x^39 + x^58).
package scrambler_64b66b_pkg;

    localparam int STATE_W = 58;
    localparam int TAP_A   = 39;
    localparam int TAP_B   = 58;

    localparam logic [STATE_W-1:0] DEFAULT_SEED = 58'h3ff_ffff_ffff_ffff;

    // Bit counter only needs to reach STATE_W; 7 bits leaves headroom before saturation.
    localparam int               CNT_W   = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/scrambler_64b66b_lane.sv
// One channel of the 64b/66b scrambler/descrambler: state, lock counter and output register.
module scrambler_64b66b_lane
    import scrambler_64b66b_pkg::*;
#(
    parameter int                 LEN     = 32,
    parameter int                 DESCRAM = 0,
    parameter logic [STATE_W-1:0] SEED    = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               valid_i,
    input  logic [LEN-1:0]     data_i,
    input  logic               bypass_i,
    input  logic               load_i,
    input  logic [STATE_W-1:0] seed_i,
    output logic               valid_o,
    output logic [LEN-1:0]     data_o,
    output logic               locked_o
);

    localparam logic [CNT_W:0]   CNT_INC  = (CNT_W + 1)'(LEN);
    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(STATE_W);

    logic [STATE_W-1:0]     state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   locked_q, locked_d;
    logic                   valid_q, valid_d;
    logic [LEN-1:0]         data_q, data_d;

    // hist[0] is the oldest line bit (S_(n-58)); the beat's new line bits are appended above the state.
    logic [STATE_W+LEN-1:0] hist;
    logic [LEN-1:0]         result;
    logic                   fb;

    // Add one beat's worth of bits, sticking at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a);
        logic [CNT_W:0] sum;
        sum     = {1'b0, a} + CNT_INC;
        sat_add = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    // Unrolled per-bit recurrence; later bits see earlier bits of the same beat through hist.
    always_comb begin
        hist               = '0;
        hist[STATE_W-1:0]  = load_i ? seed_i : state_q;
        result             = '0;
        fb                 = 1'b0;
        for (int j = 0; j < LEN; j++) begin
            fb = hist[j + STATE_W - TAP_A] ^ hist[j + STATE_W - TAP_B];
            if (DESCRAM != 0) begin
                hist[STATE_W + j] = data_i[j];
                result[j]         = data_i[j] ^ fb;
            end else begin
                hist[STATE_W + j] = data_i[j] ^ fb;
                result[j]         = hist[STATE_W + j];
            end
        end
    end

    // Next-state selection: load first, then a beat (which may build on the freshly loaded seed).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        if (load_i) begin
            state_d  = seed_i;
            cnt_d    = '0;
            locked_d = 1'b0;
        end
        if (valid_i) begin
            state_d  = hist[LEN +: STATE_W];
            cnt_d    = sat_add(cnt_d);
            locked_d = locked_d | (cnt_d >= LOCK_CNT);
            valid_d  = 1'b1;
            data_d   = bypass_i ? data_i : result;
        end
    end

    // Register everything; reset wins over load and valid.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= SEED;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign locked_o = locked_q;

endmodule

// File: rtl/scrambler_64b66b_ml.sv
// Multi-lane 64b/66b scrambler/descrambler: CH independent lanes of LEN bits per beat.
module scrambler_64b66b_ml
    import scrambler_64b66b_pkg::*;
#(
    parameter int                 LEN     = 32,
    parameter int                 CH      = 1,
    parameter int                 DESCRAM = 0,
    parameter logic [STATE_W-1:0] SEED    = DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [CH-1:0]       valid_i,
    input  logic [CH*LEN-1:0]   data_i,
    input  logic                bypass_i,
    input  logic [CH-1:0]       load_i,
    input  logic [STATE_W-1:0]  seed_i,
    output logic [CH-1:0]       valid_o,
    output logic [CH*LEN-1:0]   data_o,
    output logic [CH-1:0]       locked_o
);

    for (genvar c = 0; c < CH; c++) begin : g_lane
        scrambler_64b66b_lane #(
            .LEN     (LEN),
            .DESCRAM (DESCRAM),
            .SEED    (SEED)
        ) u_lane (
            .clk      (clk),
            .nreset   (nreset),
            .valid_i  (valid_i[c]),
            .data_i   (data_i[c*LEN +: LEN]),
            .bypass_i (bypass_i),
            .load_i   (load_i[c]),
            .seed_i   (seed_i),
            .valid_o  (valid_o[c]),
            .data_o   (data_o[c*LEN +: LEN]),
            .locked_o (locked_o[c])
        );
    end

endmodule

// File: tb/tb_scrambler_64b66b_ml.sv
// Bench: scrambler feeding a descrambler (2 channels, 32-bit beats), checked against a bit-stream model.
module tb_scrambler_64b66b_ml;

    localparam int LEN = 32;
    localparam int CH  = 2;
    localparam logic [57:0] ALL1 = 58'h3ff_ffff_ffff_ffff;

    logic          clk = 1'b0;
    logic          nreset;
    logic [CH-1:0] s_valid, s_load, d_load;
    logic          s_bypass, d_bypass;
    logic [63:0]   s_data;
    logic [57:0]   s_seed, d_seed;

    logic [CH-1:0] scr_valid_o, scr_locked_o, dsc_valid_o, dsc_locked_o;
    logic [63:0]   scr_data_o, dsc_data_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    scrambler_64b66b_ml #(.LEN(LEN), .CH(CH), .DESCRAM(0)) u_scr (
        .clk(clk), .nreset(nreset), .valid_i(s_valid), .data_i(s_data),
        .bypass_i(s_bypass), .load_i(s_load), .seed_i(s_seed),
        .valid_o(scr_valid_o), .data_o(scr_data_o), .locked_o(scr_locked_o)
    );

    scrambler_64b66b_ml #(.LEN(LEN), .CH(CH), .DESCRAM(1)) u_dsc (
        .clk(clk), .nreset(nreset), .valid_i(scr_valid_o), .data_i(scr_data_o),
        .bypass_i(d_bypass), .load_i(d_load), .seed_i(d_seed),
        .valid_o(dsc_valid_o), .data_o(dsc_data_o), .locked_o(dsc_locked_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: line-bit histories per channel ----------------
    bit          sq [CH][$];   // last 58 bits on the scrambled line, scrambler side
    bit          dq [CH][$];   // last 58 received line bits, descrambler side
    int          s_bits [CH];
    int          d_bits [CH];
    logic [CH-1:0] m_s_valid, m_s_locked, m_d_valid, m_d_locked;
    logic [63:0] m_s_data, m_d_data;

    always @(posedge clk) begin
        logic [63:0]   in_d;
        logic [CH-1:0] in_v;
        logic [57:0]   sd;
        logic [31:0]   ob;
        bit            b, lb;
        in_d = m_s_data;
        in_v = m_s_valid;
        for (int c = 0; c < CH; c++) begin
            // scrambler side
            if (!nreset) begin
                sd = ALL1;
                sq[c].delete();
                for (int k = 0; k < 58; k++) sq[c].push_back(sd[k]);
                s_bits[c] = 0; m_s_valid[c] = 1'b0; m_s_locked[c] = 1'b0;
                m_s_data[c*LEN +: LEN] = '0;
            end else begin
                if (s_load[c]) begin
                    sd = s_seed;
                    sq[c].delete();
                    for (int k = 0; k < 58; k++) sq[c].push_back(sd[k]);
                    s_bits[c] = 0; m_s_locked[c] = 1'b0;
                end
                m_s_valid[c] = s_valid[c];
                if (s_valid[c]) begin
                    for (int j = 0; j < LEN; j++) begin
                        b  = s_data[c*LEN + j];
                        lb = b ^ sq[c][sq[c].size() - 39] ^ sq[c][sq[c].size() - 58];
                        sq[c].push_back(lb);
                        void'(sq[c].pop_front());
                        ob[j] = s_bypass ? b : lb;
                    end
                    m_s_data[c*LEN +: LEN] = ob;
                    s_bits[c] += LEN;
                    if (s_bits[c] >= 58) m_s_locked[c] = 1'b1;
                end
            end
            // descrambler side, fed by the scrambler's previous-cycle output
            if (!nreset) begin
                sd = ALL1;
                dq[c].delete();
                for (int k = 0; k < 58; k++) dq[c].push_back(sd[k]);
                d_bits[c] = 0; m_d_valid[c] = 1'b0; m_d_locked[c] = 1'b0;
                m_d_data[c*LEN +: LEN] = '0;
            end else begin
                if (d_load[c]) begin
                    sd = d_seed;
                    dq[c].delete();
                    for (int k = 0; k < 58; k++) dq[c].push_back(sd[k]);
                    d_bits[c] = 0; m_d_locked[c] = 1'b0;
                end
                m_d_valid[c] = in_v[c];
                if (in_v[c]) begin
                    for (int j = 0; j < LEN; j++) begin
                        lb = in_d[c*LEN + j];
                        b  = lb ^ dq[c][dq[c].size() - 39] ^ dq[c][dq[c].size() - 58];
                        dq[c].push_back(lb);
                        void'(dq[c].pop_front());
                        ob[j] = d_bypass ? lb : b;
                    end
                    m_d_data[c*LEN +: LEN] = ob;
                    d_bits[c] += LEN;
                    if (d_bits[c] >= 58) m_d_locked[c] = 1'b1;
                end
            end
        end
    end

    // every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("scr_valid",  scr_valid_o,  m_s_valid);
            chk("scr_data",   scr_data_o,   m_s_data);
            chk("scr_locked", scr_locked_o, m_s_locked);
            chk("dsc_valid",  dsc_valid_o,  m_d_valid);
            chk("dsc_data",   dsc_data_o,   m_d_data);
            chk("dsc_locked", dsc_locked_o, m_d_locked);
        end
    end

    // ---------------- end-to-end loopback checker ----------------
    logic [31:0] lq [CH][$];
    logic        dbyp_d1;
    logic [63:0] dsc_in_d1;

    always @(posedge clk) begin
        dbyp_d1   <= d_bypass;
        dsc_in_d1 <= scr_data_o;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        for (int c = 0; c < CH; c++) begin
            if (dsc_valid_o[c] && lq[c].size() > 0) begin
                e = lq[c].pop_front();
                if (dbyp_d1) chk("dsc_bypass_passthru", dsc_data_o[c*LEN +: LEN], dsc_in_d1[c*LEN +: LEN]);
                else         chk("loopback", dsc_data_o[c*LEN +: LEN], e);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int          sent [CH];
        logic [63:0] d, prev_d;
        logic [CH-1:0] v;
        logic [63:0] ob [8];
        bit          prev_byp;

        nreset = 1'b0; s_valid = '0; s_load = '0; d_load = '0;
        s_bypass = 1'b0; d_bypass = 1'b0; s_data = '0; s_seed = '0; d_seed = '0;

        // reset state
        @(posedge clk); #1 chk_en = 1;
        @(negedge clk);
        chk("rst scr_valid", scr_valid_o, 0);
        chk("rst scr_data", scr_data_o, 0);
        chk("rst scr_locked", scr_locked_o, 0);
        chk("rst dsc_data", dsc_data_o, 0);

        // known vector on channel 0, channel 1 idle
        nreset = 1'b1; s_valid = 2'b01; s_data = {32'h0, 32'h0000001e};
        @(negedge clk);
        chk("kv beat1", scr_data_o[31:0], 32'h0000001e);
        chk("kv lock after 32b", scr_locked_o, 2'b00);
        chk("kv ch1 idle", scr_valid_o, 2'b01);
        s_data = '0;
        @(negedge clk);
        chk("kv beat2", scr_data_o[31:0], 32'h7bfff080);
        chk("kv lock after 64b", scr_locked_o, 2'b01);
        chk("kv dsc beat1", dsc_data_o[31:0], 32'h0000001e);
        s_valid = '0;
        @(negedge clk);
        chk("kv dsc beat2", dsc_data_o[31:0], 32'h0);
        chk("kv dsc lock", dsc_locked_o, 2'b01);
        chk("kv hold", scr_data_o[31:0], 32'h7bfff080);
        repeat (2) @(negedge clk);

        // loopback with random valid gaps
        sent[0] = 0; sent[1] = 0;
        while (sent[0] < 100 || sent[1] < 100) begin
            v = '0;
            for (int c = 0; c < CH; c++)
                if (sent[c] < 100 && $urandom_range(0, 3) != 0) begin v[c] = 1'b1; sent[c]++; end
            d = {$urandom(), $urandom()};
            s_valid = v; s_data = d;
            for (int c = 0; c < CH; c++) if (v[c]) lq[c].push_back(d[c*LEN +: LEN]);
            @(negedge clk);
        end
        s_valid = '0;
        repeat (3) @(negedge clk);
        chk("loop drained ch0", lq[0].size(), 0);
        chk("loop drained ch1", lq[1].size(), 0);

        // descrambler bypass for 3 beats mid-stream
        for (int i = 0; i < 14; i++) begin
            d = {$urandom(), $urandom()};
            s_valid = 2'b11; s_data = d;
            d_bypass = (i >= 6 && i <= 8);
            lq[0].push_back(d[31:0]); lq[1].push_back(d[63:32]);
            @(negedge clk);
        end
        s_valid = '0; d_bypass = 1'b0;
        repeat (3) @(negedge clk);
        chk("byp drained ch0", lq[0].size(), 0);
        chk("byp drained ch1", lq[1].size(), 0);

        // scrambler bypass: raw data out
        prev_byp = 0; prev_d = '0;
        for (int i = 0; i < 7; i++) begin
            if (prev_byp) chk("scr bypass", scr_data_o, prev_d);
            d = {$urandom(), $urandom()};
            s_valid = (i < 6) ? 2'b11 : 2'b00; s_data = d;
            s_bypass = (i >= 2 && i <= 4);
            prev_byp = s_bypass; prev_d = d;
            @(negedge clk);
        end
        s_bypass = 1'b0;

        // lock: descrambler seeded with zero, scrambler from SEED
        nreset = 1'b0; s_valid = '0;
        @(negedge clk);
        nreset = 1'b1; d_load = 2'b11; d_seed = '0;
        @(negedge clk);
        d_load = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) chk("lock after beat1", dsc_locked_o, 2'b00);
            if (i == 3) chk("lock after beat2", dsc_locked_o, 2'b11);
            if (i >= 4) chk("lock data match", dsc_data_o, ob[i-2]);
            if (i < 8) begin
                ob[i] = {$urandom(), $urandom()};
                s_valid = 2'b11; s_data = ob[i];
            end else begin
                s_valid = '0;
            end
        end

        // load and beat together on channel 0
        @(negedge clk);
        s_valid = 2'b11; s_load = 2'b01; s_seed = ALL1; s_data = {$urandom(), 32'h0000001e};
        @(negedge clk);
        s_load = '0;
        chk("load+valid data", scr_data_o[31:0], 32'h0000001e);
        chk("load+valid lock", scr_locked_o, 2'b10);
        s_data = {$urandom(), 32'h0};
        @(negedge clk);
        chk("load+valid next", scr_data_o[31:0], 32'h7bfff080);
        chk("load+valid relock", scr_locked_o, 2'b11);
        s_valid = '0; s_load = 2'b10;
        @(negedge clk);
        s_load = '0;
        chk("load only ch1", scr_locked_o, 2'b01);

        // mid-stream reset
        s_valid = 2'b11; s_data = {$urandom(), $urandom()};
        @(negedge clk);
        nreset = 1'b0; s_data = {$urandom(), $urandom()};
        @(negedge clk);
        chk("midrst valid", scr_valid_o, 0);
        chk("midrst locked", scr_locked_o, 0);
        chk("midrst data", scr_data_o, 0);
        chk("midrst dsc valid", dsc_valid_o, 0);
        nreset = 1'b1; s_valid = 2'b01; s_data = {32'h0, 32'h0000001e};
        @(negedge clk);
        chk("post-rst beat1", scr_data_o[31:0], 32'h0000001e);
        s_data = '0;
        @(negedge clk);
        chk("post-rst beat2", scr_data_o[31:0], 32'h7bfff080);
        s_valid = '0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
